// File: rtl/jtbubl_arb_pkg.sv
// rtl/jtbubl_arb_pkg.sv - shared state encoding, port ids and stats width for the shared RAM arbiter
package jtbubl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int STAT_W = 16;

endpackage

// File: rtl/jtbubl_arb_port.sv
// rtl/jtbubl_arb_port.sv - per-CPU done flag, read capture, wait_n and optional stall counter (JTBUBL_ARB_STATS_EN)
module jtbubl_arb_port
    import jtbubl_arb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              fin,
    input  logic              rd,
    input  logic [DW-1:0]     ram_q,
    output logic [DW-1:0]     dout,
    output logic              wait_n
`ifdef JTBUBL_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    logic done;

    // The CPU stalls from the very cycle cs rises until its access has completed
    assign wait_n = ~(cs & ~done);

    // done is only set if the CPU still holds cs when the sequence ends; dropping cs always clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else if (!cs) begin
            done <= 1'b0;
        end else if (fin) begin
            done <= 1'b1;
        end
    end

    // Read data is captured at the end of every read sequence, even a withdrawn one, and held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (fin && rd) begin
            dout <= ram_q;
        end
    end

`ifdef JTBUBL_ARB_STATS_EN
    // Saturating count of cycles this CPU spends stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!wait_n && (stall_cnt != {STAT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/jtbubl_share_arb.sv
// rtl/jtbubl_share_arb.sv - time-shares one single-port work RAM between main and sub Z80s (stats: JTBUBL_ARB_STATS_EN)
module jtbubl_share_arb
    import jtbubl_arb_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic              clk24,
    input  logic              rst_n,
    input  logic              a_cs,
    input  logic              a_we,
    input  logic [AW-1:0]     a_addr,
    input  logic [DW-1:0]     a_din,
    output logic [DW-1:0]     a_dout,
    output logic              a_wait_n,
    input  logic              b_cs,
    input  logic              b_we,
    input  logic [AW-1:0]     b_addr,
    input  logic [DW-1:0]     b_din,
    output logic [DW-1:0]     b_dout,
    output logic              b_wait_n,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_din,
    output logic              ram_we,
    input  logic [DW-1:0]     ram_q
`ifdef JTBUBL_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] a_stall_cnt,
    output logic [STAT_W-1:0] b_stall_cnt
`endif
);

    arb_state_t state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q;
    logic       gnt_we_q;
    logic       a_pend, b_pend;
    logic       a_fin, b_fin;

    // A pending request is exactly a stalled CPU
    assign a_pend = ~a_wait_n;
    assign b_pend = ~b_wait_n;

    assign a_fin = (state_q == DATA) && (gnt_q == PORT_A);
    assign b_fin = (state_q == DATA) && (gnt_q == PORT_B);

    // Next state and grant; arbitration only happens in IDLE so a granted access runs to completion
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (a_pend || b_pend) begin
                    state_d = GNT;
                    if (a_pend && b_pend) begin
                        gnt_d = ~last_q;
                    end else begin
                        gnt_d = b_pend ? PORT_B : PORT_A;
                    end
                end
            end
            GNT:     state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant and round-robin history; last starts at B so A wins the first tie
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= PORT_A;
            last_q  <= PORT_B;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            if (state_q == DATA) begin
                last_q <= gnt_q;
            end
        end
    end

    // RAM side: address/data latched at grant, write enable high only for the single GNT cycle
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
            gnt_we_q <= 1'b0;
        end else if (state_q == IDLE && state_d == GNT) begin
            ram_addr <= (gnt_d == PORT_B) ? b_addr : a_addr;
            ram_din  <= (gnt_d == PORT_B) ? b_din  : a_din;
            ram_we   <= (gnt_d == PORT_B) ? b_we   : a_we;
            gnt_we_q <= (gnt_d == PORT_B) ? b_we   : a_we;
        end else begin
            ram_we   <= 1'b0;
        end
    end

    jtbubl_arb_port #(.DW(DW)) u_port_a (
        .clk       (clk24),
        .rst_n     (rst_n),
        .cs        (a_cs),
        .fin       (a_fin),
        .rd        (~gnt_we_q),
        .ram_q     (ram_q),
        .dout      (a_dout),
        .wait_n    (a_wait_n)
`ifdef JTBUBL_ARB_STATS_EN
        ,
        .stall_cnt (a_stall_cnt)
`endif
    );

    jtbubl_arb_port #(.DW(DW)) u_port_b (
        .clk       (clk24),
        .rst_n     (rst_n),
        .cs        (b_cs),
        .fin       (b_fin),
        .rd        (~gnt_we_q),
        .ram_q     (ram_q),
        .dout      (b_dout),
        .wait_n    (b_wait_n)
`ifdef JTBUBL_ARB_STATS_EN
        ,
        .stall_cnt (b_stall_cnt)
`endif
    );

endmodule

// File: tb/tb_jtbubl_share_arb.sv
// tb/tb_jtbubl_share_arb.sv - directed-vector bench for jtbubl_share_arb (stats checks under JTBUBL_ARB_STATS_EN)
module tb_jtbubl_share_arb;

    logic        clk24 = 1'b0;
    logic        rst_n;
    logic        a_cs, a_we, b_cs, b_we;
    logic [12:0] a_addr, b_addr;
    logic [7:0]  a_din, b_din;
    logic [7:0]  a_dout, b_dout;
    logic        a_wait_n, b_wait_n;
    logic [12:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [7:0]  ram_q;
`ifdef JTBUBL_ARB_STATS_EN
    logic [15:0] a_stall_cnt, b_stall_cnt;
`endif

    logic [7:0]  mem [0:8191] = '{default: 8'h00};
    int          we_pulses = 0;
    logic [12:0] we_addr = '0;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          ac, bc, p0;

    always #5 clk24 = ~clk24;

    jtbubl_share_arb #(.AW(13), .DW(8)) dut (
        .clk24    (clk24),
        .rst_n    (rst_n),
        .a_cs     (a_cs),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_dout   (a_dout),
        .a_wait_n (a_wait_n),
        .b_cs     (b_cs),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_dout   (b_dout),
        .b_wait_n (b_wait_n),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_q    (ram_q)
`ifdef JTBUBL_ARB_STATS_EN
        ,
        .a_stall_cnt (a_stall_cnt),
        .b_stall_cnt (b_stall_cnt)
`endif
    );

    // Single-port RAM with one-cycle read latency; fixed preloads are reapplied while in reset
    always @(posedge clk24) begin
        if (!rst_n) begin
            mem[13'h0123] <= 8'h5A;
            mem[13'h0200] <= 8'h11;
            mem[13'h0AAA] <= 8'h3C;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_q <= mem[ram_addr];
    end

    // Write strobe monitor
    always @(posedge clk24) begin
        if (ram_we === 1'b1) begin
            we_pulses <= we_pulses + 1;
            we_addr   <= ram_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise the enabled selects together, hold each until its wait_n releases, report stalled cycles
    task automatic run(input logic ae, input logic awe, input logic [12:0] aad, input logic [7:0] adi,
                       input logic be, input logic bwe, input logic [12:0] bad, input logic [7:0] bdi,
                       output int acnt, output int bcnt);
        @(negedge clk24);
        a_cs = ae; a_we = awe; a_addr = aad; a_din = adi;
        b_cs = be; b_we = bwe; b_addr = bad; b_din = bdi;
        acnt = 0;
        bcnt = 0;
        for (int i = 0; i < 16 && (a_cs || b_cs); i++) begin
            #1;
            if (a_cs) begin
                if (!a_wait_n) acnt++; else a_cs = 1'b0;
            end
            if (b_cs) begin
                if (!b_wait_n) bcnt++; else b_cs = 1'b0;
            end
            if (a_cs || b_cs) @(negedge clk24);
        end
        check("timeout", {31'd0, a_cs | b_cs}, 32'd0);
        a_cs = 1'b0; b_cs = 1'b0; a_we = 1'b0; b_we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_cs = 0; a_we = 0; a_addr = '0; a_din = '0;
        b_cs = 0; b_we = 0; b_addr = '0; b_din = '0;
        repeat (3) @(negedge clk24);
        check("rst_ram_we", {31'd0, ram_we}, 32'd0);
        check("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
        check("rst_ram_din", {24'd0, ram_din}, 32'd0);
        check("rst_a_dout", {24'd0, a_dout}, 32'd0);
        check("rst_b_dout", {24'd0, b_dout}, 32'd0);
        check("rst_a_wait", {31'd0, a_wait_n}, 32'd1);
        check("rst_b_wait", {31'd0, b_wait_n}, 32'd1);
        rst_n = 1'b1;

        // First tie after reset: A first
        run(1, 0, 13'h0200, 8'h00, 1, 0, 13'h0AAA, 8'h00, ac, bc);
        check("tie1_a_cyc", ac, 3);
        check("tie1_b_cyc", bc, 6);
        check("tie1_a_dout", {24'd0, a_dout}, 32'h11);
        check("tie1_b_dout", {24'd0, b_dout}, 32'h3C);
`ifdef JTBUBL_ARB_STATS_EN
        check("stat_a", {16'd0, a_stall_cnt}, 32'd3);
        check("stat_b", {16'd0, b_stall_cnt}, 32'd6);
`endif

        // Single uncontended read
        p0 = we_pulses;
        run(1, 0, 13'h0123, 8'h00, 0, 0, 13'h0000, 8'h00, ac, bc);
        check("rd_a_cyc", ac, 3);
        check("rd_a_dout", {24'd0, a_dout}, 32'h5A);
        check("rd_no_we", we_pulses - p0, 0);

        // A served last, so the next tie goes to B
        run(1, 0, 13'h0AAA, 8'h00, 1, 0, 13'h0123, 8'h00, ac, bc);
        check("tie2_a_cyc", ac, 6);
        check("tie2_b_cyc", bc, 3);
        check("tie2_a_dout", {24'd0, a_dout}, 32'h3C);
        check("tie2_b_dout", {24'd0, b_dout}, 32'h5A);

        // Single write at the top address, then read back from the other CPU
        p0 = we_pulses;
        run(0, 0, 13'h0000, 8'h00, 1, 1, 13'h1FFF, 8'hC3, ac, bc);
        check("wr_b_cyc", bc, 3);
        check("wr_pulses", we_pulses - p0, 1);
        check("wr_addr", {19'd0, we_addr}, 32'h1FFF);
        check("wr_mem", {24'd0, mem[13'h1FFF]}, 32'hC3);
        check("wr_b_dout_held", {24'd0, b_dout}, 32'h5A);
        run(1, 0, 13'h1FFF, 8'h00, 0, 0, 13'h0000, 8'h00, ac, bc);
        check("rdbk_a_dout", {24'd0, a_dout}, 32'hC3);

        // Withdrawal during DATA of a write
        @(negedge clk24);
        a_cs = 1; a_we = 1; a_addr = 13'h0040; a_din = 8'h77;
        repeat (2) @(negedge clk24);
        a_cs = 0; a_we = 0;
        @(negedge clk24);
        #1;
        check("wd_wait", {31'd0, a_wait_n}, 32'd1);
        check("wd_mem", {24'd0, mem[13'h0040]}, 32'h77);
        run(1, 0, 13'h0040, 8'h00, 0, 0, 13'h0000, 8'h00, ac, bc);
        check("wd_fresh_cyc", ac, 3);
        check("wd_fresh_dout", {24'd0, a_dout}, 32'h77);

        // Reset while a write is granted but not yet performed
        @(negedge clk24);
        a_cs = 1; a_we = 1; a_addr = 13'h0500; a_din = 8'hEE;
        @(negedge clk24);
        #1;
        check("mid_pre_we", {31'd0, ram_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_ram_we", {31'd0, ram_we}, 32'd0);
        check("mid_a_dout", {24'd0, a_dout}, 32'd0);
        check("mid_b_dout", {24'd0, b_dout}, 32'd0);
        a_cs = 0; a_we = 0;
        #1;
        check("mid_a_wait", {31'd0, a_wait_n}, 32'd1);
        check("mid_b_wait", {31'd0, b_wait_n}, 32'd1);
        repeat (2) @(negedge clk24);
        check("mid_no_write", {24'd0, mem[13'h0500]}, 32'h00);
        rst_n = 1'b1;
        run(1, 0, 13'h0123, 8'h00, 1, 0, 13'h1FFF, 8'h00, ac, bc);
        check("tie3_a_cyc", ac, 3);
        check("tie3_b_cyc", bc, 6);
        check("tie3_a_dout", {24'd0, a_dout}, 32'h5A);
        check("tie3_b_dout", {24'd0, b_dout}, 32'hC3);

`ifdef JTBUBL_ARB_STATS_EN
        // Saturation of the stall counter
        @(negedge clk24);
        force dut.u_port_a.stall_cnt = 16'hFFFE;
        #1;
        release dut.u_port_a.stall_cnt;
        run(1, 0, 13'h0123, 8'h00, 0, 0, 13'h0000, 8'h00, ac, bc);
        check("stat_sat", {16'd0, a_stall_cnt}, 32'hFFFF);
`endif

        repeat (2) @(negedge clk24);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
